// File: rtl/bird_game_core.sv
// Bird physics, IDLE/PLAY/DEAD game state and survival score, advanced on a divided game tick.
// Also overlays the bird box onto the VGA pixel stream with one clock of latency.
module bird_game_core #(
  parameter int CW        = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BIRD_X    = 100,
  parameter int BIRD_SIZE = 40,
  parameter int TICK_DIV  = 100000,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = 8,
  parameter int MAX_FALL  = 12,
  parameter int SW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] x_crd,
  input  logic [CW-1:0] y_crd,
  input  logic          btn_pressed,
  output logic          red_ch,
  output logic          green_ch,
  output logic          blue_ch,
  output logic [CW-1:0] bird_y,
  output logic [SW-1:0] score,
  output logic          game_over,
  output logic          tick
);

  localparam int VW = CW + 2;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] Y0 = CW'((V_RES - BIRD_SIZE) / 2);
  localparam logic [CW-1:0] Y_MAX = CW'(V_RES - BIRD_SIZE);

  localparam logic signed [VW-1:0] GRAV_S = VW'(GRAVITY);
  localparam logic signed [VW-1:0] FLAP_S = VW'(-FLAP_VEL);
  localparam logic signed [VW-1:0] MAX_S  = VW'(MAX_FALL);
  localparam logic signed [VW-1:0] YMAX_S = VW'(V_RES - BIRD_SIZE);
  localparam logic signed [VW-1:0] ZERO_S = VW'(0);

  localparam logic [CW:0] BX_LO = (CW+1)'(BIRD_X);
  localparam logic [CW:0] BX_HI = (CW+1)'(BIRD_X + BIRD_SIZE);
  localparam logic [CW:0] HR_E  = (CW+1)'(H_RES);
  localparam logic [CW:0] VR_E  = (CW+1)'(V_RES);
  localparam logic [CW:0] BS_E  = (CW+1)'(BIRD_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic                   btn_q;
  logic                   flap_req;
  logic                   flap_edge;
  logic                   req;
  logic signed [VW-1:0]   vel;
  logic signed [VW-1:0]   vel_cur;
  logic signed [VW-1:0]   vel_n;
  logic signed [VW-1:0]   y_n;
  logic                   die_top;
  logic                   die_bot;
  logic                   play_step;

  function automatic logic signed [VW-1:0] clamp_fall(input logic signed [VW-1:0] v);
    return (v > MAX_S) ? MAX_S : v;
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (&s) ? s : s + SW'(1);
  endfunction

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign flap_edge = btn_pressed & ~btn_q;
  assign req       = flap_req | flap_edge;

  // IDLE enters PLAY from rest, so the physics step starts from zero velocity there
  always_comb begin
    vel_cur   = (state == S_PLAY) ? vel : ZERO_S;
    vel_n     = req ? FLAP_S : clamp_fall(vel_cur + GRAV_S);
    y_n       = $signed({2'b00, bird_y}) + vel_n;
    die_top   = (y_n <= ZERO_S);
    die_bot   = (y_n >= YMAX_S);
    play_step = tick && ((state == S_PLAY) || ((state == S_IDLE) && req));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bird_y    <= Y0;
      vel       <= ZERO_S;
      score     <= '0;
      game_over <= 1'b0;
      tick_cnt  <= '0;
      flap_req  <= 1'b0;
      btn_q     <= 1'b0;
    end else begin
      btn_q    <= btn_pressed;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick)
        flap_req <= 1'b0;
      else if (flap_edge)
        flap_req <= 1'b1;

      if (play_step) begin
        if (die_top || die_bot) begin
          bird_y    <= die_top ? '0 : Y_MAX;
          vel       <= ZERO_S;
          state     <= S_DEAD;
          game_over <= 1'b1;
        end else begin
          bird_y <= y_n[CW-1:0];
          vel    <= vel_n;
          state  <= S_PLAY;
        end
        if (state == S_IDLE)
          score <= '0;
        else if (!(die_top || die_bot))
          score <= sat_inc(score);
      end else if (tick && (state == S_DEAD) && req) begin
        state     <= S_IDLE;
        bird_y    <= Y0;
        vel       <= ZERO_S;
        game_over <= 1'b0;
      end
    end
  end

  logic [CW:0] x_e_p0, y_e_p0, ytop_p0, ybot_p0;
  logic        active_p0, hit_p0;

  // Render stage 0: widened compares so BIRD_X+BIRD_SIZE and bird_y+BIRD_SIZE cannot wrap
  always_comb begin
    x_e_p0    = {1'b0, x_crd};
    y_e_p0    = {1'b0, y_crd};
    ytop_p0   = {1'b0, bird_y};
    ybot_p0   = {1'b0, bird_y} + BS_E;
    active_p0 = (x_e_p0 < HR_E) && (y_e_p0 < VR_E);
    hit_p0    = active_p0 && (x_e_p0 >= BX_LO) && (x_e_p0 < BX_HI) &&
                (y_e_p0 >= ytop_p0) && (y_e_p0 < ybot_p0);
  end

  // Render stage 1: registered colour pins
  always_ff @(posedge clk) begin
    if (rst) begin
      red_ch   <= 1'b0;
      green_ch <= 1'b0;
      blue_ch  <= 1'b0;
    end else begin
      red_ch   <= hit_p0 && (state == S_DEAD);
      green_ch <= hit_p0 && (state != S_DEAD);
      blue_ch  <= active_p0 && !hit_p0;
    end
  end

endmodule

// File: tb/tb_bird_game_core.sv
// Directed bench for bird_game_core with a reference model of the game rules feeding a scoreboard.
module tb_bird_game_core;
  localparam int CW = 10;
  localparam int SW = 16;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] x, y;
  logic          btn;
  logic          red_ch, green_ch, blue_ch;
  logic [CW-1:0] bird_y;
  logic [SW-1:0] score;
  logic          game_over;
  logic          tick;

  always #5 clk = ~clk;

  bird_game_core #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .x_crd(x), .y_crd(y), .btn_pressed(btn),
    .red_ch(red_ch), .green_ch(green_ch), .blue_ch(blue_ch),
    .bird_y(bird_y), .score(score), .game_over(game_over), .tick(tick)
  );

  typedef struct { string tag; int exp; } exp_t;
  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  // Reference model: 0=IDLE 1=PLAY 2=DEAD, default game constants
  int m_state, m_y, m_vel, m_score;

  function automatic void push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endfunction

  task automatic pop_check(input int obs);
    exp_t e;
    n_total = n_total + 1;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.exp = -1;
    end else begin
      e = sb.pop_front();
    end
    assert (obs === e.exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * TD + 2 && !found; i++) begin
      if (tick === 1'b1) found = 1'b1;
      else step();
    end
    n_total = n_total + 1;
    assert (found) n_pass = n_pass + 1;
    else $error("FAIL tick_timeout observed=0 expected=1");
  endtask

  function automatic void model_tick(input bit req);
    int  nv, ny;
    bit  first;
    first = 1'b0;
    if (m_state == 1 || (m_state == 0 && req)) begin
      if (m_state == 0) begin
        m_score = 0;
        first   = 1'b1;
      end
      nv = req ? -8 : ((m_vel + 1 > 12) ? 12 : m_vel + 1);
      ny = m_y + nv;
      if (ny <= 0) begin
        m_y = 0; m_vel = 0; m_state = 2;
      end else if (ny >= 440) begin
        m_y = 440; m_vel = 0; m_state = 2;
      end else begin
        m_y = ny; m_vel = nv; m_state = 1;
        if (!first) m_score = (m_score == 65535) ? 65535 : m_score + 1;
      end
    end else if (m_state == 2 && req) begin
      m_state = 0; m_y = 220; m_vel = 0;
    end
  endfunction

  task automatic do_tick(input bit press_now, input bit req);
    wait_tick();
    if (press_now) btn = 1'b1;
    model_tick(req);
    push("bird_y", m_y);
    push("score", m_score);
    push("game_over", (m_state == 2) ? 1 : 0);
    step();
    btn = 1'b0;
    pop_check(int'(bird_y));
    pop_check(int'(score));
    pop_check(int'(game_over));
  endtask

  task automatic pixel(input int px, input int py, input int er, input int eg, input int eb);
    x = CW'(px);
    y = CW'(py);
    push("red_ch", er);
    push("green_ch", eg);
    push("blue_ch", eb);
    step();
    pop_check(int'(red_ch));
    pop_check(int'(green_ch));
    pop_check(int'(blue_ch));
  endtask

  task automatic check_reset_state();
    push("rst_bird_y", 220);
    push("rst_score", 0);
    push("rst_game_over", 0);
    push("rst_red", 0);
    push("rst_green", 0);
    push("rst_blue", 0);
    pop_check(int'(bird_y));
    pop_check(int'(score));
    pop_check(int'(game_over));
    pop_check(int'(red_ch));
    pop_check(int'(green_ch));
    pop_check(int'(blue_ch));
  endtask

  initial begin
    int held;
    rst = 1'b1;
    btn = 1'b0;
    x   = CW'(300);
    y   = CW'(100);
    m_state = 0; m_y = 220; m_vel = 0; m_score = 0;
    step();
    step();
    check_reset_state();
    push("tick_at_reset", 0);
    pop_check(int'(tick));
    rst = 1'b0;

    // Idle: tick period and frozen IDLE state
    for (int k = 1; k <= 40; k++) begin
      step();
      push("tick_period", (k % TD == TD - 1) ? 1 : 0);
      pop_check(int'(tick));
    end
    push("idle_bird_y", 220);
    pop_check(int'(bird_y));
    push("idle_game_over", 0);
    pop_check(int'(game_over));

    // One-cycle press between ticks, then three unassisted ticks
    btn = 1'b1;
    step();
    btn = 1'b0;
    do_tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0);
    push("y_after_three", 194);
    pop_check(int'(bird_y));
    push("score_after_three", 3);
    pop_check(int'(score));

    // Free fall to the floor clamp
    for (int i = 0; i < 60 && m_state != 2; i++) do_tick(1'b0, 1'b0);
    push("y_floor", 440);
    pop_check(int'(bird_y));
    push("dead_flag", 1);
    pop_check(int'(game_over));
    pixel(110, 450, 1, 0, 0);
    do_tick(1'b0, 1'b0);

    // DEAD -> IDLE keeps score, then a press landing on the tick cycle
    held = m_score;
    do_tick(1'b1, 1'b1);
    push("score_held", held);
    pop_check(int'(score));
    do_tick(1'b1, 1'b1);
    do_tick(1'b0, 1'b0);
    push("no_pending_flap", 205);
    pop_check(int'(bird_y));

    // Flap every tick up to the ceiling clamp
    for (int i = 0; i < 60 && m_state != 2; i++) do_tick(1'b1, 1'b1);
    push("y_ceiling", 0);
    pop_check(int'(bird_y));
    do_tick(1'b1, 1'b1);
    push("y_back_idle", 220);
    pop_check(int'(bird_y));
    do_tick(1'b1, 1'b1);
    push("score_restart", 0);
    pop_check(int'(score));
    pixel(110, 220, 0, 1, 0);

    // Reset in the middle of PLAY, between ticks
    do_tick(1'b0, 1'b0);
    step();
    x   = CW'(300);
    y   = CW'(100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_state = 0; m_y = 220; m_vel = 0; m_score = 0;
    check_reset_state();
    for (int k = 1; k <= TD - 1; k++) begin
      step();
      push("tick_after_reset", (k == TD - 1) ? 1 : 0);
      pop_check(int'(tick));
    end
    pixel(639, 479, 0, 0, 1);
    pixel(640, 0, 0, 0, 0);
    pixel(110, 225, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
